// File: rtl/sram_stream_reader.sv
// sram_stream_reader: burst read client for the dual-port SRAM wrapper.
// Issues one read per cycle while output credit allows. It absorbs the
// 1-cycle SRAM read latency and presents the words as a valid/ready stream
// through a small FIFO.
// Optional feature macro: SRAM_STREAM_READER_STRIDE_EN adds a `stride` port.
// It sets the address step, which is otherwise fixed at 1.
//
// Handshake: a word moves downstream in any cycle where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and
// out_data holds steady while out_valid is high and out_ready is low.
`timescale 1ns/1ps
module sram_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
`ifdef SRAM_STREAM_READER_STRIDE_EN
   input  logic [ADDR_WIDTH-1:0] stride,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  mem_csb,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = CW + 2;
   localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   state_t                state_q, state_d;
   logic                  launch, issue, finish, zero_burst;
   logic                  csb_q, rvalid_q, done_q;
   logic [ADDR_WIDTH-1:0] addr_q, next_addr_q, step_in, step_q;
   logic [ADDR_WIDTH:0]   req_left_q, xfer_left_q;
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic                  pop, credit_ok;
   logic [SW-1:0]         credit_sum;

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign mem_csb   = csb_q;
   assign mem_addr  = addr_q;
   assign out_valid = (count_q != '0);
   assign out_data  = fifo_mem[rd_ptr_q];
   assign pop       = out_valid & out_ready;

   // Words already held, plus the word landing now, plus the request on the
   // SRAM port this cycle, must leave room for one more request.
   assign credit_sum = SW'(count_q) + SW'(rvalid_q) + SW'(csb_q) - SW'(pop);
   assign credit_ok  = (credit_sum < SW'(FIFO_DEPTH));

`ifdef SRAM_STREAM_READER_STRIDE_EN
   assign step_in = stride;
   // Capture the burst stride at launch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         step_q <= '0;
      else if (launch) step_q <= stride;
   end
`else
   assign step_in = ADDR_ONE;
   assign step_q  = ADDR_ONE;
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and per-cycle launch/issue/finish decisions.
   always_comb begin
      state_d    = state_q;
      launch     = 1'b0;
      issue      = 1'b0;
      finish     = 1'b0;
      zero_burst = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (length != LEN_ZERO) begin
                  launch  = 1'b1;
                  state_d = S_READ;
               end else begin
                  zero_burst = 1'b1;
               end
            end
         end
         S_READ: begin
            if (req_left_q == LEN_ZERO) begin
               state_d = S_DRAIN;
            end else if (credit_ok) begin
               issue = 1'b1;
               if (req_left_q == LEN_ONE) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && (xfer_left_q == LEN_ONE)) begin
               finish  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // SRAM request port, burst counters and done pulse.
   // The first request goes out on the start edge so the address appears the next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csb_q       <= 1'b0;
         addr_q      <= '0;
         next_addr_q <= '0;
         req_left_q  <= '0;
         xfer_left_q <= '0;
         rvalid_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         rvalid_q <= csb_q;
         done_q   <= finish | zero_burst;
         if (launch) begin
            csb_q       <= 1'b1;
            addr_q      <= base_addr;
            next_addr_q <= base_addr + step_in;
            req_left_q  <= length - LEN_ONE;
         end else if (issue) begin
            csb_q       <= 1'b1;
            addr_q      <= next_addr_q;
            next_addr_q <= next_addr_q + step_q;
            req_left_q  <= req_left_q - LEN_ONE;
         end else begin
            csb_q <= 1'b0;
         end
         if (launch)
            xfer_left_q <= length;
         else if (pop && (state_q != S_IDLE))
            xfer_left_q <= xfer_left_q - LEN_ONE;
      end
   end

   // Output FIFO: returning SRAM data is pushed unconditionally, and the credit check keeps it from overflowing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (rvalid_q) begin
            fifo_mem[wr_ptr_q] <= mem_dout;
            wr_ptr_q           <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CW'(rvalid_q) - CW'(pop);
      end
   end

endmodule
